fft_out_reorder: RTL and testbench
==================================

// Module: fft_out_reorder
// PURPOSE
//  Output reorder buffer that sits directly after the last butterfly stage of the 16-point FFT pipeline.
//  - Accepts one complex sample per iEN cycle, in the bit-reversed order the butterfly chain produces.
//  - Writes each frame into one half of a ping-pong RAM at address bitrev(write count).
//  - Streams the completed frame out in natural bin order (X[0]..X[N-1]) while the next frame fills
//    the other half.
// PARAMETERS
//  N     16  points per frame (power of 2)
//  LOGN  4   log2(N); width of the write and read counters
//  WL    16  bits per real/imag component; RE/IM format is passed through unchanged (Q(16,6) in this pipeline)
// PORTS
//  iCLK   in   1      clock, rising edge
//  iRSTn  in   1      asynchronous active-low reset
//  iCLR   in   1      synchronous clear; overrides all other inputs
//  iEN    in   1      iDATA valid this cycle
//  iDATA  in   2*WL   {RE, IM} sample from the butterfly stage
//  oEN    out  1      oDATA valid
//  oDATA  out  2*WL   {RE, IM} frequency bin, natural order
//  oSOF   out  1      first bin of a frame; present only with FFT_REORDER_SOF_EN
// BEHAVIOUR
//  - Storage: 2 banks x N words x 2*WL bits (flop array or inferred RAM).
//  - State: wcnt[LOGN-1:0], wbank, rcnt[LOGN-1:0], rbank, rd_active.
//  - Reset (iRSTn=0, async) and iCLR=1 (sync) clear all state and outputs to the same values:
//    - wcnt=0, wbank=0, rcnt=0, rd_active=0
//    - oEN=0, oDATA=0, oSOF=0
//    - RAM contents are not cleared.
//  - iCLR has priority over iEN. Any partial frame being written is discarded, and any frame being
//    read out is aborted: oEN=0 from the next edge.
//  - Write path, on each edge with iEN=1:
//    - mem[wbank][bitrev(wcnt)] <= iDATA; wcnt <= wcnt+1, wrapping at N.
//    - When wcnt==N-1 the frame is complete: wbank toggles; rbank <= old wbank; rcnt <= 0; rd_active <= 1.
//    - iEN=0 holds wcnt. Gaps of any length are allowed within a frame.
//  - Read FSM, states IDLE (rd_active=0) and READ (rd_active=1):
//    - READ, each edge: oDATA <= mem[rbank][rcnt]; oEN <= 1; rcnt <= rcnt+1.
//    - When rcnt==N-1 and no new frame completes on the same edge: rd_active <= 0. oEN falls on the
//      edge after the last bin is output.
//    - IDLE: oEN <= 0; oDATA holds its last value.
//  - Latency: frame completes on edge t; bin k appears on oDATA with oEN=1 after edge t+1+k, k=0..N-1.
//    oEN is independent of iEN once a read is active.
//  - Back-to-back frames (iEN held high): the next frame completes on edge t+N. This is the same edge
//    that launches bin N-1 of the current frame.
//    - The completion reloads rbank and sets rcnt=0, so rd_active stays 1.
//    - oEN stays high with no gap and the next frame's bin 0 follows on edge t+N+1.
//    - Overflow is therefore impossible: a frame needs >= N write cycles and readout takes exactly N.
//  - Reads and writes never touch the same bank in the same cycle: wbank != rbank whenever rd_active=1.
//  - Reset mid-operation: behaves as a fresh start. The first iEN after release is sample 0 of a new frame.
//  - Arithmetic: none. Data passes bit-exact. bitrev() reverses the LOGN index bits (e.g. 0001 -> 1000).
// CONFIGURATION
//  - FFT_REORDER_SOF_EN defined: adds output port oSOF.
//    - oSOF is registered and asserted together with oEN for bin 0 of each frame only.
//    - Reset/clear value 0.
//  - FFT_REORDER_SOF_EN undefined: no oSOF port and no SOF logic. All other behaviour is identical.
// TESTING
//  1. Assert iRSTn=0 mid-stream, then release.
//     -> oEN=0, oDATA=0 immediately.
//     -> The first 16 iEN samples after release form frame 0.
//  2. One frame, iEN high for 16 cycles, iDATA={n,16'd0} for n=0..15.
//     -> Edge after last write: oEN=1.
//     -> RE sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15, i.e. X[k] = sample bitrev(k); IM=0.
//     -> oEN low after 16 cycles.
//  3. Same frame, but iEN toggles 1,0,1,0...
//     -> Identical output sequence, starting one edge after the 16th accepted sample.
//     -> oEN high for exactly 16 consecutive cycles.
//  4. Three frames back-to-back, iEN high for 48 cycles, iDATA={frame,n}.
//     -> oEN high for 48 contiguous cycles.
//     -> Each frame appears in bit-reversed-corrected order with no gap or duplicate.
//  5. iCLR pulsed after 7 samples of frame 1 while frame 0 is reading out.
//     -> oEN=0 on the next edge.
//     -> The following 16 samples are output as a complete frame; nothing from the aborted frame appears.
//  6. With FFT_REORDER_SOF_EN, run test 4.
//     -> oSOF=1 exactly on cycles 0, 16 and 32 of the oEN window, and 0 otherwise.

Source files
------------

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: frames arrive in bit-reversed order and leave in natural bin order.
// Optional frame-start flag oSOF is built only when FFT_REORDER_SOF_EN is defined.
module fft_out_reorder #(
   parameter int N    = 16,
   parameter int LOGN = 4,
   parameter int WL   = 16
) (
   input  logic            iCLK,
   input  logic            iRSTn,
   input  logic            iCLR,
   input  logic            iEN,
   input  logic [2*WL-1:0] iDATA,
   output logic            oEN,
   output logic [2*WL-1:0] oDATA
`ifdef FFT_REORDER_SOF_EN
   ,
   output logic            oSOF
`endif
);

   typedef enum logic {IDLE = 1'b0, READ = 1'b1} rd_state_e;

   rd_state_e       state_q, state_d;
   logic [LOGN-1:0] wcnt_q, wcnt_d;
   logic [LOGN-1:0] rcnt_q, rcnt_d;
   logic            wbank_q, wbank_d;
   logic            rbank_q, rbank_d;
   logic            oen_q, oen_d;
   logic [2*WL-1:0] odata_q, odata_d;
   logic [LOGN-1:0] wcnt_rev;
   logic            frame_done;
   logic [2*WL-1:0] mem [2*N];

   generate
      for (genvar gi = 0; gi < LOGN; gi++) begin : g_bitrev
         assign wcnt_rev[gi] = wcnt_q[LOGN-1-gi];
      end
   endgenerate

   assign frame_done = iEN && (wcnt_q == LOGN'(N-1));

   // Bank select is the address MSB; the RAM itself is never reset.
   always_ff @(posedge iCLK) begin
      if (!iCLR && iEN)
         mem[{wbank_q, wcnt_rev}] <= iDATA;
   end

`ifdef FFT_REORDER_SOF_EN
   logic sof_q, sof_d;
`endif

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      oen_d   = oen_q;
      odata_d = odata_q;
`ifdef FFT_REORDER_SOF_EN
      sof_d   = 1'b0;
`endif
      if (iCLR) begin
         state_d = IDLE;
         wcnt_d  = '0;
         rcnt_d  = '0;
         wbank_d = 1'b0;
         rbank_d = 1'b0;
         oen_d   = 1'b0;
         odata_d = '0;
      end else begin
         if (iEN)
            wcnt_d = wcnt_q + 1'b1;
         case (state_q)
            IDLE: oen_d = 1'b0;
            READ: begin
               odata_d = mem[{rbank_q, rcnt_q}];
               oen_d   = 1'b1;
               rcnt_d  = rcnt_q + 1'b1;
`ifdef FFT_REORDER_SOF_EN
               sof_d   = (rcnt_q == '0);
`endif
               if (rcnt_q == LOGN'(N-1))
                  state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
         // A completing frame wins over the end-of-read so back-to-back frames stream gap-free.
         if (frame_done) begin
            wbank_d = ~wbank_q;
            rbank_d = wbank_q;
            rcnt_d  = '0;
            state_d = READ;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn) begin
         state_q <= IDLE;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         wbank_q <= 1'b0;
         rbank_q <= 1'b0;
         oen_q   <= 1'b0;
         odata_q <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         oen_q   <= oen_d;
         odata_q <= odata_d;
      end
   end

`ifdef FFT_REORDER_SOF_EN
   always_ff @(posedge iCLK or negedge iRSTn) begin
      if (!iRSTn)
         sof_q <= 1'b0;
      else
         sof_q <= sof_d;
   end

   assign oSOF = sof_q;
`endif

   assign oEN   = oen_q;
   assign oDATA = odata_q;

endmodule

// File: tb/tb_fft_out_reorder.sv
// Self-checking bench for fft_out_reorder: a per-cycle schedule model predicts every output word.
// Define FFT_REORDER_SOF_EN to also check the oSOF flag.
module tb_fft_out_reorder;

   localparam int N    = 16;
   localparam int LOGN = 4;
   localparam int WL   = 16;

   logic            clk   = 1'b0;
   logic            rst_n = 1'b0;
   logic            clr   = 1'b0;
   logic            en    = 1'b0;
   logic [2*WL-1:0] data  = '0;
   logic            oen;
   logic [2*WL-1:0] odata;
`ifdef FFT_REORDER_SOF_EN
   logic            osof;
`endif

   always #5 clk = ~clk;

   fft_out_reorder #(.N(N), .LOGN(LOGN), .WL(WL)) dut (
      .iCLK  (clk),
      .iRSTn (rst_n),
      .iCLR  (clr),
      .iEN   (en),
      .iDATA (data),
      .oEN   (oen),
      .oDATA (odata)
`ifdef FFT_REORDER_SOF_EN
      ,
      .oSOF  (osof)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: output words scheduled by absolute cycle number.
   logic [2*WL-1:0] sched_data [int];
   bit              sched_sof  [int];
   logic [2*WL-1:0] fbuf [N];
   int              fcnt      = 0;
   logic [2*WL-1:0] last_data = '0;
   logic            exp_en    = 1'b0;
   logic [2*WL-1:0] exp_data  = '0;
   logic            exp_sof   = 1'b0;

   function automatic int bitrev(int k);
      int r = 0;
      for (int b = 0; b < LOGN; b++)
         if ((k >> b) & 1) r |= 1 << (LOGN - 1 - b);
      return r;
   endfunction

   task automatic model_clear();
      sched_data.delete();
      sched_sof.delete();
      fcnt      = 0;
      last_data = '0;
   endtask

   // Advance one clock; update the model with the inputs seen at that edge; settle 1 time unit.
   task automatic step();
      @(posedge clk);
      cyc++;
      if (!rst_n || clr) begin
         model_clear();
      end else if (en) begin
         fbuf[fcnt] = data;
         fcnt++;
         if (fcnt == N) begin
            for (int k = 0; k < N; k++) begin
               sched_data[cyc + 1 + k] = fbuf[bitrev(k)];
               sched_sof[cyc + 1 + k]  = (k == 0);
            end
            fcnt = 0;
         end
      end
      if (sched_data.exists(cyc)) begin
         exp_en    = 1'b1;
         exp_data  = sched_data[cyc];
         exp_sof   = sched_sof[cyc];
         last_data = exp_data;
         sched_data.delete(cyc);
         sched_sof.delete(cyc);
      end else begin
         exp_en   = 1'b0;
         exp_data = last_data;
         exp_sof  = 1'b0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (oen !== 1'b0 || odata !== '0) begin
         n_fail++;
         $display("FAIL reset_state oEN=%b oDATA=%h expected oEN=0 oDATA=0", oen, odata);
      end
      repeat (2) step();
      rst_n = 1'b1;
      model_clear();
      $display("test_reset: oEN=%b oDATA=%h", oen, odata);
   endtask

   task automatic test_single_frame();
      int re_tab [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
      int idx = 0;
      for (int i = 0; i < N + 24; i++) begin
         en   = (i < N);
         data = (i < N) ? {16'(i), 16'd0} : '0;
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL single_frame cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
         if (oen === 1'b1) begin
            n_checks++;
            if (idx >= N || odata !== {16'(re_tab[idx < N ? idx : 0]), 16'd0}) begin
               n_fail++;
               $display("FAIL single_frame_order bin=%0d oDATA=%h expected RE=%0d IM=0",
                        idx, odata, re_tab[idx < N ? idx : 0]);
            end
            idx++;
         end
      end
      n_checks++;
      if (idx != N) begin
         n_fail++;
         $display("FAIL single_frame_count bins=%0d expected %0d", idx, N);
      end
      $display("test_single_frame: %0d bins observed", idx);
   endtask

   task automatic test_gapped();
      int run = 0, max_run = 0, total = 0;
      en = 1'b0;
      for (int i = 0; i < 2 * N + 24; i++) begin
         en   = (i < 2 * N) && (i % 2 == 0);
         data = $urandom;
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL gapped cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
         if (oen === 1'b1) begin run++; total++; if (run > max_run) max_run = run; end
         else run = 0;
      end
      n_checks++;
      if (max_run != N || total != N) begin
         n_fail++;
         $display("FAIL gapped_window run=%0d total=%0d expected %0d", max_run, total, N);
      end
      $display("test_gapped: oEN run %0d cycles", max_run);
   endtask

   task automatic test_back_to_back();
      int run = 0, max_run = 0, total = 0, sof_cnt = 0;
      for (int i = 0; i < 3 * N + 24; i++) begin
         en   = (i < 3 * N);
         data = {16'(i / N), 16'(i % N)};
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL back_to_back cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
`ifdef FFT_REORDER_SOF_EN
         n_checks++;
         if (osof !== (oen === 1'b1 && (run % N) == 0)) begin
            n_fail++;
            $display("FAIL back_to_back_sof cyc=%0d oSOF=%b window_pos=%0d", i, osof, run);
         end
         if (osof === 1'b1) sof_cnt++;
`endif
         if (oen === 1'b1) begin run++; total++; if (run > max_run) max_run = run; end
         else run = 0;
      end
      n_checks++;
      if (max_run != 3 * N || total != 3 * N) begin
         n_fail++;
         $display("FAIL back_to_back_window run=%0d total=%0d expected %0d", max_run, total, 3 * N);
      end
`ifdef FFT_REORDER_SOF_EN
      n_checks++;
      if (sof_cnt != 3) begin
         n_fail++;
         $display("FAIL back_to_back_sof_count count=%0d expected 3", sof_cnt);
      end
`endif
      $display("test_back_to_back: oEN run %0d cycles, sof %0d", max_run, sof_cnt);
   endtask

   task automatic test_clear();
      int total_after = 0;
      for (int i = 0; i < 2 * N + 8 + N + 24; i++) begin
         clr  = (i == 2 * N + 7 - N + N - N + 7 + N - 7) ? 1'b1 : 1'b0;
         clr  = (i == N + 7);
         en   = (i < 2 * N + 8 + N) && (i != N + 7 || 1'b1);
         en   = (i < 2 * N + 8);
         data = $urandom;
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL clear cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
         if (i == N + 7) begin
            n_checks++;
            if (oen !== 1'b0 || odata !== '0) begin
               n_fail++;
               $display("FAIL clear_abort oEN=%b oDATA=%h expected oEN=0 oDATA=0", oen, odata);
            end
         end
         if (i > N + 7 && oen === 1'b1) total_after++;
      end
      clr = 1'b0;
      n_checks++;
      if (total_after != N) begin
         n_fail++;
         $display("FAIL clear_frame_count bins=%0d expected %0d", total_after, N);
      end
      $display("test_clear: %0d bins after clear", total_after);
   endtask

   task automatic test_reset_midstream();
      for (int i = 0; i < N + 5; i++) begin
         en   = 1'b1;
         data = $urandom;
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL midreset_pre cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (oen !== 1'b0 || odata !== '0) begin
         n_fail++;
         $display("FAIL midreset_async oEN=%b oDATA=%h expected oEN=0 oDATA=0", oen, odata);
      end
      model_clear();
      repeat (2) step();
      rst_n = 1'b1;
      for (int i = 0; i < N + 24; i++) begin
         en   = (i < N);
         data = $urandom;
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL midreset_post cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
      end
      $display("test_reset_midstream: done");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 3) != 0);
         clr  = ($urandom_range(0, 99) == 0);
         data = $urandom;
         step();
         n_checks++;
         if (oen !== exp_en || odata !== exp_data) begin
            n_fail++;
            $display("FAIL random cyc=%0d oEN=%b oDATA=%h expected oEN=%b oDATA=%h",
                     i, oen, odata, exp_en, exp_data);
         end
      end
      clr = 1'b0;
      en  = 1'b0;
      $display("test_random: done");
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_gapped();
      test_back_to_back();
      test_clear();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
